// File: rtl/cp_strip_framer.sv
`default_nettype none
// ============================================================================
// Module  : cp_strip_framer
// Brief   : Skips a trigger offset, then forwards FFT windows and drops cyclic
//           prefixes, one packet per window, for up to max_frames symbols.
// Revision: 1.0
// ============================================================================
module cp_strip_framer #(
    parameter int SR_BASE        = 16,
    parameter int DEF_FRAME_LEN  = 64,
    parameter int DEF_GAP_LEN    = 16,
    parameter int DEF_OFFSET     = 0,
    parameter int DEF_MAX_FRAMES = 1,
    parameter int CNT_W          = 16
) (
    input  logic             ce_clk,
    input  logic             ce_rst,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [31:0]      i_tdata,
    input  logic             i_trig,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [31:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [CNT_W-1:0] o_frame_idx,
    output logic             busy
);

    localparam logic [7:0] c_ADDR_FRAME_LEN  = 8'(SR_BASE + 0);
    localparam logic [7:0] c_ADDR_GAP_LEN    = 8'(SR_BASE + 1);
    localparam logic [7:0] c_ADDR_OFFSET     = 8'(SR_BASE + 2);
    localparam logic [7:0] c_ADDR_MAX_FRAMES = 8'(SR_BASE + 3);
    localparam logic [7:0] c_ADDR_CLEAR      = 8'(SR_BASE + 4);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OFFSET = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] frame_len_q, gap_len_q, offset_q, max_frames_q;
    logic [CNT_W-1:0] sh_frame_m1_q, sh_gap_m1_q, sh_off_m1_q, sh_max_q;
    logic             sh_gap_zero_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] frame_idx_q;
    logic             clear_pend_q;

    logic             w_clear;
    logic             w_trig_ok;
    logic             w_direct;
    logic             w_pass;
    logic             w_beat;
    logic             w_last;
    logic             w_done;
    logic             w_gap_zero;
    logic [CNT_W-1:0] w_cfg_frame_m1;
    logic [CNT_W-1:0] w_frame_m1;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_fcnt;
    logic [CNT_W-1:0] w_max;
    logic [CNT_W-1:0] w_idx_nxt;
    state_t           w_after_last;
    logic             w_unused_data;

    assign w_unused_data = ^set_data[31:CNT_W];

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            frame_len_q  <= CNT_W'(DEF_FRAME_LEN);
            gap_len_q    <= CNT_W'(DEF_GAP_LEN);
            offset_q     <= CNT_W'(DEF_OFFSET);
            max_frames_q <= CNT_W'(DEF_MAX_FRAMES);
        end else if (set_stb) begin
            case (set_addr)
                c_ADDR_FRAME_LEN:  frame_len_q  <= set_data[CNT_W-1:0];
                c_ADDR_GAP_LEN:    gap_len_q    <= set_data[CNT_W-1:0];
                c_ADDR_OFFSET:     offset_q     <= set_data[CNT_W-1:0];
                c_ADDR_MAX_FRAMES: max_frames_q <= set_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    assign w_clear        = set_stb && (set_addr == c_ADDR_CLEAR);
    assign w_cfg_frame_m1 = (frame_len_q == '0) ? '0 : frame_len_q - 1'b1;
    assign w_trig_ok      = i_trig && (max_frames_q != '0);

    // With a zero offset the trigger beat itself is frame sample 0, so it must
    // already be passed through (and back-pressured) while still in IDLE.
    assign w_direct = (state_q == S_IDLE) && i_tvalid && w_trig_ok && (offset_q == '0);
    assign w_pass   = (state_q == S_FRAME) || w_direct;

    assign w_frame_m1 = (state_q == S_FRAME) ? sh_frame_m1_q : w_cfg_frame_m1;
    assign w_cnt      = (state_q == S_FRAME) ? cnt_q         : '0;
    assign w_fcnt     = (state_q == S_FRAME) ? frame_idx_q   : '0;
    assign w_max      = (state_q == S_FRAME) ? sh_max_q      : max_frames_q;
    assign w_gap_zero = (state_q == S_FRAME) ? sh_gap_zero_q : (gap_len_q == '0);
    assign w_idx_nxt  = w_fcnt + 1'b1;
    assign w_last     = w_pass && (w_cnt == w_frame_m1);
    assign w_done     = (w_idx_nxt == w_max) || clear_pend_q ||
                        ((state_q == S_FRAME) && w_clear);
    assign w_after_last = w_done ? S_IDLE : (w_gap_zero ? S_FRAME : S_GAP);

    assign i_tready    = ce_rst && (w_pass ? o_tready : 1'b1);
    assign w_beat      = i_tvalid && i_tready;
    assign o_tvalid    = ce_rst && w_pass && i_tvalid;
    assign o_tlast     = o_tvalid && w_last;
    assign o_tdata     = i_tdata;
    assign o_frame_idx = frame_idx_q;
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            frame_idx_q   <= '0;
            clear_pend_q  <= 1'b0;
            sh_frame_m1_q <= '0;
            sh_gap_m1_q   <= '0;
            sh_off_m1_q   <= '0;
            sh_max_q      <= '0;
            sh_gap_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_beat && w_trig_ok) begin
                        sh_frame_m1_q <= w_cfg_frame_m1;
                        sh_gap_m1_q   <= gap_len_q - 1'b1;
                        sh_off_m1_q   <= offset_q - 1'b1;
                        sh_max_q      <= max_frames_q;
                        sh_gap_zero_q <= (gap_len_q == '0);
                        clear_pend_q  <= 1'b0;
                        frame_idx_q   <= '0;
                        if (offset_q == '0) begin
                            if (w_last) begin
                                state_q     <= w_after_last;
                                cnt_q       <= '0;
                                frame_idx_q <= w_done ? '0 : w_idx_nxt;
                            end else begin
                                state_q <= S_FRAME;
                                cnt_q   <= CNT_W'(1);
                            end
                        end else if (offset_q == CNT_W'(1)) begin
                            state_q <= S_FRAME;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_OFFSET;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                S_OFFSET: begin
                    if (w_clear) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (w_beat) begin
                        if (cnt_q == sh_off_m1_q) begin
                            state_q <= S_FRAME;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_FRAME: begin
                    if (w_clear) begin
                        clear_pend_q <= 1'b1;
                    end
                    if (w_beat) begin
                        if (w_last) begin
                            state_q     <= w_after_last;
                            cnt_q       <= '0;
                            frame_idx_q <= w_done ? '0 : w_idx_nxt;
                            if (w_done) begin
                                clear_pend_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_clear) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        frame_idx_q <= '0;
                    end else if (w_beat) begin
                        if (cnt_q == sh_gap_m1_q) begin
                            state_q <= S_FRAME;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp_strip_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cp_strip_framer
// Brief   : Ramp-stream bench for cp_strip_framer against a burst-level model.
// Revision: 1.0
// ============================================================================
module tb_cp_strip_framer;

    localparam int CNT_W  = 16;
    localparam int BUDGET = 20000;

    logic             ce_clk = 1'b0;
    logic             ce_rst = 1'b0;
    logic             set_stb = 1'b0;
    logic [7:0]       set_addr = '0;
    logic [31:0]      set_data = '0;
    logic [31:0]      i_tdata = '0;
    logic             i_trig = 1'b0;
    logic             i_tvalid = 1'b0;
    logic             i_tready;
    logic [31:0]      o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready = 1'b0;
    logic [CNT_W-1:0] o_frame_idx;
    logic             busy;

    cp_strip_framer dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_trig(i_trig), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_frame_idx(o_frame_idx), .busy(busy)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct packed {
        logic        last;
        logic [15:0] idx;
        logic [31:0] data;
    } beat_t;

    beat_t       out_q[$];
    beat_t       exp_q[$];
    int          trig_q[$];
    int          n = 0;
    int          checks = 0;
    int          failures = 0;
    bit          busy_seen, wr_arm, wr_done = 1'b1, busy_after_wr;
    int          wr_n;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    function automatic bit is_trig(int v);
        foreach (trig_q[i]) if (trig_q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Burst model: window k starts at trig+offset+k*(frame+gap); a clear ends
    // the burst after the window containing it, or before the next window.
    function automatic void add_burst(int trig, int fl, int gl, int off, int mx, int clr);
        int eff;
        int start;
        beat_t b;
        eff = (fl == 0) ? 1 : fl;
        for (int k = 0; k < mx; k++) begin
            start = trig + off + k * (eff + gl);
            if (clr >= 0 && clr < start) break;
            for (int j = 0; j < eff; j++) begin
                b.last = (j == eff - 1);
                b.idx  = 16'(k);
                b.data = 32'(start + j);
                exp_q.push_back(b);
            end
            if (clr >= start && clr < start + eff) break;
        end
    endfunction

    function automatic int first_diff();
        int m;
        m = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (out_q[i] !== exp_q[i]) return i;
        if (out_q.size() != exp_q.size()) return m;
        return -1;
    endfunction

    function automatic beat_t got_at(int i);
        return (i < out_q.size()) ? out_q[i] : 'x;
    endfunction

    function automatic beat_t exp_at(int i);
        return (i < exp_q.size()) ? exp_q[i] : 'x;
    endfunction

    task automatic write_reg(input int a, input int d);
        i_tvalid = 1'b0;
        set_stb  = 1'b1;
        set_addr = 8'(16 + a);
        set_data = 32'(d);
        @(posedge ce_clk); #1;
        set_stb  = 1'b0;
    endtask

    task automatic configure(input int fl, input int gl, input int off, input int mx);
        write_reg(0, fl);
        write_reg(1, gl);
        write_reg(2, off);
        write_reg(3, mx);
    endtask

    task automatic start_test();
        out_q.delete();
        exp_q.delete();
        trig_q.delete();
        busy_seen = 1'b0;
        wr_done   = 1'b1;
        wr_arm    = 1'b0;
    endtask

    task automatic schedule_write(input int at_n, input int a, input int d);
        wr_n    = at_n;
        wr_addr = 8'(16 + a);
        wr_data = 32'(d);
        wr_done = 1'b0;
    endtask

    task automatic run(input int stop_n, input int pv, input int pr);
        int    cyc;
        bit    inb;
        beat_t b;
        cyc     = 0;
        i_tdata = 32'(n);
        i_trig  = is_trig(n);
        while (n < stop_n && cyc < BUDGET) begin
            @(negedge ce_clk);
            if (wr_arm) begin
                busy_after_wr = busy;
                wr_arm = 1'b0;
            end
            if (busy) busy_seen = 1'b1;
            if (o_tvalid && o_tready) begin
                b.last = o_tlast;
                b.idx  = o_frame_idx;
                b.data = o_tdata;
                out_q.push_back(b);
            end
            inb = i_tvalid && i_tready;
            @(posedge ce_clk); #1;
            if (set_stb) wr_arm = 1'b1;
            set_stb = 1'b0;
            if (inb) n++;
            i_tdata  = 32'(n);
            i_trig   = is_trig(n);
            i_tvalid = ($urandom_range(99) < pv);
            o_tready = ($urandom_range(99) < pr);
            if (!wr_done && n == wr_n) begin
                set_stb  = 1'b1;
                set_addr = wr_addr;
                set_data = wr_data;
                wr_done  = 1'b1;
            end
            cyc++;
        end
        checks++;
        if (cyc >= BUDGET) begin
            $display("FAIL run_timeout: reached sample %0d, required %0d", n, stop_n);
            failures++;
        end
    endtask

    task automatic test_reset();
        i_tvalid = 1'b1;
        o_tready = 1'b1;
        i_trig   = 1'b1;
        #3;
        checks += 5;
        if (o_tvalid !== 1'b0) begin $display("FAIL reset_tvalid: got %b want 0", o_tvalid); failures++; end
        if (o_tlast !== 1'b0) begin $display("FAIL reset_tlast: got %b want 0", o_tlast); failures++; end
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); failures++; end
        if (i_tready !== 1'b0) begin $display("FAIL reset_tready: got %b want 0", i_tready); failures++; end
        if (o_frame_idx !== '0) begin $display("FAIL reset_idx: got %0d want 0", o_frame_idx); failures++; end
        i_trig   = 1'b0;
        i_tvalid = 1'b0;
        @(posedge ce_clk); #1;
        ce_rst = 1'b1;
        @(posedge ce_clk); #1;
    endtask

    task automatic test_ramp();
        int base, d;
        start_test();
        configure(64, 16, 20, 12);
        base = n;
        trig_q.push_back(base + 100);
        add_burst(base + 100, 64, 16, 20, 12, -1);
        run(base + 1200, 100, 100);
        d = first_diff();
        checks += 3;
        if (d >= 0) begin
            $display("FAIL ramp_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
        if (busy !== 1'b0) begin $display("FAIL ramp_busy_end: got %b want 0", busy); failures++; end
        if (busy_seen !== 1'b1) begin $display("FAIL ramp_busy_seen: got %b want 1", busy_seen); failures++; end
    endtask

    task automatic test_backpressure();
        int base, d;
        start_test();
        base = n;
        trig_q.push_back(base + 100);
        add_burst(base + 100, 64, 16, 20, 12, -1);
        run(base + 1200, 70, 50);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            $display("FAIL backpressure_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
    endtask

    task automatic test_short_frames();
        int base, d;
        start_test();
        configure(4, 0, 0, 3);
        base = n;
        trig_q.push_back(base + 10);
        add_burst(base + 10, 4, 0, 0, 3, -1);
        run(base + 40, 100, 100);
        d = first_diff();
        checks += 2;
        if (d >= 0) begin
            $display("FAIL short_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
        if (busy !== 1'b0) begin $display("FAIL short_busy_end: got %b want 0", busy); failures++; end
    endtask

    task automatic test_frame_len_zero();
        int base, d;
        start_test();
        configure(0, 2, 0, 3);
        base = n;
        trig_q.push_back(base + 5);
        add_burst(base + 5, 0, 2, 0, 3, -1);
        run(base + 30, 80, 70);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            $display("FAIL zero_len_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
    endtask

    task automatic test_retrigger_config();
        int base, d;
        start_test();
        configure(64, 16, 20, 3);
        base = n;
        trig_q.push_back(base + 100);
        trig_q.push_back(base + 200);
        trig_q.push_back(base + 500);
        schedule_write(base + 150, 0, 32);
        add_burst(base + 100, 64, 16, 20, 3, -1);
        add_burst(base + 500, 32, 16, 20, 3, -1);
        run(base + 700, 80, 60);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            $display("FAIL retrigger_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
    endtask

    task automatic test_clear();
        int base, d;
        start_test();
        configure(64, 16, 20, 12);
        base = n;
        trig_q.push_back(base + 100);
        schedule_write(base + 310, 4, 1);
        add_burst(base + 100, 64, 16, 20, 12, base + 310);
        run(base + 700, 100, 100);
        d = first_diff();
        checks += 3;
        if (d >= 0) begin
            $display("FAIL clear_frame_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
        if (busy_after_wr !== 1'b1) begin $display("FAIL clear_frame_busy_after: got %b want 1", busy_after_wr); failures++; end
        if (busy !== 1'b0) begin $display("FAIL clear_frame_busy_end: got %b want 0", busy); failures++; end

        start_test();
        base = n;
        trig_q.push_back(base + 50);
        schedule_write(base + 140, 4, 1);
        add_burst(base + 50, 64, 16, 20, 12, base + 140);
        run(base + 400, 100, 100);
        d = first_diff();
        checks += 2;
        if (d >= 0) begin
            $display("FAIL clear_gap_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
        if (busy_after_wr !== 1'b0) begin $display("FAIL clear_gap_busy_after: got %b want 0", busy_after_wr); failures++; end
    endtask

    task automatic test_max_zero();
        int base;
        start_test();
        configure(64, 16, 0, 0);
        base = n;
        trig_q.push_back(base + 10);
        run(base + 100, 100, 100);
        checks += 2;
        if (out_q.size() != 0) begin $display("FAIL max_zero_output: got %0d beats want 0", out_q.size()); failures++; end
        if (busy_seen !== 1'b0) begin $display("FAIL max_zero_busy: got %b want 0", busy_seen); failures++; end
    endtask

    task automatic test_async_reset();
        int base, d;
        start_test();
        configure(64, 16, 0, 1);
        base = n;
        trig_q.push_back(base + 20);
        run(base + 50, 100, 100);
        i_tvalid = 1'b1;
        o_tready = 1'b1;
        #2;
        ce_rst = 1'b0;
        #1;
        checks += 3;
        if (o_tvalid !== 1'b0) begin $display("FAIL async_tvalid: got %b want 0", o_tvalid); failures++; end
        if (busy !== 1'b0) begin $display("FAIL async_busy: got %b want 0", busy); failures++; end
        if (i_tready !== 1'b0) begin $display("FAIL async_tready: got %b want 0", i_tready); failures++; end
        @(posedge ce_clk);
        @(posedge ce_clk); #1;
        ce_rst = 1'b1;

        // Defaults after reset: frame 64, gap 16, offset 0, one frame.
        start_test();
        trig_q.push_back(n + 30);
        add_burst(n + 30, 64, 16, 0, 1, -1);
        run(n + 150, 90, 80);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            $display("FAIL post_reset_stream: at %0d got %h (n=%0d) want %h (n=%0d)", d, got_at(d), out_q.size(), exp_at(d), exp_q.size());
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_short_frames();
        test_frame_len_zero();
        test_retrigger_config();
        test_clear();
        test_max_zero();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
